// File: rtl/exec_sequencer_if.sv
// Bundle of decoder-side inputs and stage/strobe outputs shared between the
// instruction sequencer and the rest of the core.
interface exec_sequencer_if #(
    parameter int unsigned IP_BITS          = 8,
    parameter int unsigned JUMP_OFFSET_BITS = 8
);
    logic                        run;
    logic                        stop;
    logic                        mem_ready;
    logic [1:0]                  op_kind;
    logic                        jump_taken;
    logic [JUMP_OFFSET_BITS-1:0] jump_offset;
    logic                        iret;
    logic                        irq;
    logic                        irq_en;

    logic [2:0]                  stage;
    logic [IP_BITS-1:0]          ip;
    logic                        fetch_req;
    logic                        reg_read_en;
    logic                        alu_en;
    logic                        reg_wr_en;
    logic                        mem_rd_req;
    logic                        mem_wr_req;
    logic                        irq_ack;
    logic                        in_isr;
    logic [IP_BITS-1:0]          saved_ip;

    // The sequencer drives stage, IP and strobes; the core environment drives the rest
    modport master (
        input  run, stop, mem_ready, op_kind, jump_taken, jump_offset, iret, irq, irq_en,
        output stage, ip, fetch_req, reg_read_en, alu_en, reg_wr_en,
               mem_rd_req, mem_wr_req, irq_ack, in_isr, saved_ip
    );

    modport slave (
        output run, stop, mem_ready, op_kind, jump_taken, jump_offset, iret, irq, irq_en,
        input  stage, ip, fetch_req, reg_read_en, alu_en, reg_wr_en,
               mem_rd_req, mem_wr_req, irq_ack, in_isr, saved_ip
    );
endinterface

// File: rtl/exec_sequencer.sv
// Instruction-cycle sequencer: walks the core through fetch, register read,
// execute, memory and write-back stages, owns the instruction pointer, resolves
// jumps and handles single-level interrupt entry and return.
module exec_sequencer #(
    parameter int unsigned          IP_BITS          = 8,
    parameter int unsigned          JUMP_OFFSET_BITS = 8,
    parameter int unsigned          INSTR_BYTES      = 2,
    parameter logic [IP_BITS-1:0]   RESET_ADDRESS    = 'h00,
    parameter logic [IP_BITS-1:0]   ISR_ADDRESS      = 'h80
) (
    input  logic              clk,
    input  logic              reset,
    exec_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        FETCH_START    = 3'd1,
        FETCH_END      = 3'd2,
        REGISTER_FETCH = 3'd3,
        EXECUTE        = 3'd4,
        REGISTER_WB    = 3'd5,
        LOAD_STAGE     = 3'd6,
        STORE_STAGE    = 3'd7
    } stage_t;

    stage_t               stage_q;
    stage_t               stage_nxt;
    logic [IP_BITS-1:0]   ip_q;
    logic [IP_BITS-1:0]   saved_ip_q;
    logic [IP_BITS-1:0]   next_ip;
    logic [IP_BITS-1:0]   offset_ext;
    logic                 in_isr_q;
    logic                 irq_q;
    logic                 irq_pending_q;
    logic                 irq_edge;
    logic                 at_boundary;
    logic                 iret_bound;
    logic                 take_irq;
    logic                 irq_ack_q;
    logic                 fetch_req_q;
    logic                 reg_read_en_q;
    logic                 alu_en_q;
    logic                 reg_wr_en_q;
    logic                 mem_rd_req_q;
    logic                 mem_wr_req_q;

    assign offset_ext = IP_BITS'($signed(bus.jump_offset));
    assign irq_edge   = bus.irq & ~irq_q;

    // Next stage, instruction-boundary detection and the address of the following instruction
    always_comb begin
        stage_nxt   = stage_q;
        at_boundary = 1'b0;
        iret_bound  = 1'b0;
        next_ip     = ip_q + IP_BITS'(INSTR_BYTES);
        unique case (stage_q)
            IDLE:           if (bus.run) stage_nxt = FETCH_START;
            FETCH_START:    stage_nxt = FETCH_END;
            FETCH_END:      if (bus.mem_ready) stage_nxt = REGISTER_FETCH;
            REGISTER_FETCH: stage_nxt = EXECUTE;
            EXECUTE: begin
                unique case (bus.op_kind)
                    2'd0: stage_nxt = REGISTER_WB;
                    2'd1: stage_nxt = LOAD_STAGE;
                    2'd2: stage_nxt = STORE_STAGE;
                    2'd3: begin
                        at_boundary = 1'b1;
                        if (bus.iret) begin
                            iret_bound = 1'b1;
                            next_ip    = saved_ip_q;
                        end else if (bus.jump_taken) begin
                            next_ip = ip_q + IP_BITS'(INSTR_BYTES) + offset_ext;
                        end
                    end
                endcase
            end
            LOAD_STAGE:     if (bus.mem_ready) stage_nxt = REGISTER_WB;
            STORE_STAGE:    if (bus.mem_ready) at_boundary = 1'b1;
            REGISTER_WB:    at_boundary = 1'b1;
        endcase
        // The return instruction itself must always complete, so no entry on its boundary
        take_irq = at_boundary & ~bus.stop & irq_pending_q & bus.irq_en & ~in_isr_q & ~iret_bound;
        if (at_boundary) begin
            stage_nxt = bus.stop ? IDLE : FETCH_START;
        end
    end

    // Stage register, IP/interrupt bookkeeping and strobes registered from the upcoming stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q       <= IDLE;
            ip_q          <= RESET_ADDRESS;
            saved_ip_q    <= '0;
            in_isr_q      <= 1'b0;
            irq_q         <= 1'b0;
            irq_pending_q <= 1'b0;
            irq_ack_q     <= 1'b0;
            fetch_req_q   <= 1'b0;
            reg_read_en_q <= 1'b0;
            alu_en_q      <= 1'b0;
            reg_wr_en_q   <= 1'b0;
            mem_rd_req_q  <= 1'b0;
            mem_wr_req_q  <= 1'b0;
        end else begin
            stage_q   <= stage_nxt;
            irq_q     <= bus.irq;
            irq_ack_q <= take_irq;

            if (at_boundary) begin
                if (take_irq) begin
                    saved_ip_q <= next_ip;
                    ip_q       <= ISR_ADDRESS;
                    in_isr_q   <= 1'b1;
                end else begin
                    ip_q <= next_ip;
                    if (iret_bound) in_isr_q <= 1'b0;
                end
            end

            if (irq_edge) begin
                irq_pending_q <= 1'b1;
            end else if (take_irq) begin
                irq_pending_q <= 1'b0;
            end

            fetch_req_q   <= (stage_nxt == FETCH_START) || (stage_nxt == FETCH_END);
            reg_read_en_q <= (stage_nxt == REGISTER_FETCH);
            alu_en_q      <= (stage_nxt == EXECUTE);
            reg_wr_en_q   <= (stage_nxt == REGISTER_WB);
            mem_rd_req_q  <= (stage_nxt == LOAD_STAGE);
            mem_wr_req_q  <= (stage_nxt == STORE_STAGE);
        end
    end

    assign bus.stage       = stage_q;
    assign bus.ip          = ip_q;
    assign bus.saved_ip    = saved_ip_q;
    assign bus.in_isr      = in_isr_q;
    assign bus.irq_ack     = irq_ack_q;
    assign bus.fetch_req   = fetch_req_q;
    assign bus.reg_read_en = reg_read_en_q;
    assign bus.alu_en      = alu_en_q;
    assign bus.reg_wr_en   = reg_wr_en_q;
    assign bus.mem_rd_req  = mem_rd_req_q;
    assign bus.mem_wr_req  = mem_wr_req_q;

endmodule
